// File: rtl/lac_host.sv
// lac_host: host-side controller for the logic-analyzer byte protocol (arm, disarm, capture readout)
// Ports: clk/reset (sync, active-high); start/abort control pulses; cfg_* arm parameters latched on start;
//        tx_data/tx_wr/tx_busy and rx_data/rx_avail/rx_ack byte UART handshakes;
//        sample_dat/sample_valid/sample_idx streamed capture; busy/done/err status.
module lac_host #(
  parameter int adr_width = 11,
  parameter int timeout_cycles = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           cfg_select,
  input  logic [7:0]           cfg_mask,
  input  logic [7:0]           cfg_cond,
  input  logic [7:0]           cfg_pre,
  output logic [7:0]           tx_data,
  output logic                 tx_wr,
  input  logic                 tx_busy,
  input  logic [7:0]           rx_data,
  input  logic                 rx_avail,
  output logic                 rx_ack,
  output logic [7:0]           sample_dat,
  output logic                 sample_valid,
  output logic [adr_width-1:0] sample_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);
  typedef enum logic [3:0] {IDLE, SEND_ARM, SEND_SEL, SEND_MASK, SEND_COND, SEND_PRE, WAIT_HDR, RECV, FIN, SEND_DIS} state_t;
  localparam logic [7:0] hdr = 8'(adr_width);
  state_t state;
  logic [7:0] sel_q, mask_q, cond_q, pre_q, tx_byte;
  logic [adr_width-1:0] cnt;
  logic [31:0] tmo;
  logic rx_req, tx_ok, tmo_hit;
  assign rx_req = rx_avail & ~rx_ack;
  assign tx_ok = ~tx_busy & ~tx_wr;
  assign tmo_hit = (timeout_cycles != 0) && (tmo == 32'(timeout_cycles - 1));
  assign busy = state != IDLE;
  always_comb begin
    tx_byte = state == SEND_SEL  ? sel_q  :
              state == SEND_MASK ? mask_q :
              state == SEND_COND ? cond_q :
              state == SEND_PRE  ? pre_q  :
              state == SEND_DIS  ? 8'h02  : 8'h01;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx_data <= '0;
      tx_wr <= 1'b0;
      rx_ack <= 1'b0;
      sample_dat <= '0;
      sample_valid <= 1'b0;
      sample_idx <= '0;
      done <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
      tmo <= '0;
      sel_q <= '0;
      mask_q <= '0;
      cond_q <= '0;
      pre_q <= '0;
    end else begin
      tx_wr <= 1'b0;
      rx_ack <= 1'b0;
      sample_valid <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_req) rx_ack <= 1'b1;
          if (start) begin
            sel_q <= cfg_select;
            mask_q <= cfg_mask;
            cond_q <= cfg_cond;
            pre_q <= cfg_pre;
            err <= 1'b0;
            // the ARM byte goes out straight away when the UART is free
            if (tx_ok) begin
              tx_wr <= 1'b1;
              tx_data <= 8'h01;
              state <= SEND_SEL;
            end else state <= SEND_ARM;
          end
        end
        SEND_ARM, SEND_SEL, SEND_MASK, SEND_COND, SEND_PRE, SEND_DIS: begin
          if (tx_ok) begin
            tx_wr <= 1'b1;
            tx_data <= tx_byte;
            tmo <= '0;
            state <= state == SEND_DIS ? IDLE : state_t'(state + 4'd1);
          end
        end
        WAIT_HDR: begin
          if (rx_req) begin
            rx_ack <= 1'b1;
            tmo <= '0;
            if (rx_data == hdr) begin
              sample_idx <= '0;
              cnt <= '0;
              state <= RECV;
            end else begin
              err <= 1'b1;
              state <= IDLE;
            end
          end else if (abort) state <= SEND_DIS;
          else if (tmo_hit) begin
            err <= 1'b1;
            state <= SEND_DIS;
          end else tmo <= tmo + 32'd1;
        end
        RECV: begin
          if (rx_req) begin
            rx_ack <= 1'b1;
            tmo <= '0;
            sample_dat <= rx_data;
            sample_valid <= 1'b1;
            sample_idx <= cnt;
            cnt <= cnt + 1'b1;
            if (&cnt) state <= FIN;
          end else if (tmo_hit) begin
            // a stalled dump means the analyzer already disarmed itself
            err <= 1'b1;
            state <= IDLE;
          end else tmo <= tmo + 32'd1;
        end
        FIN: begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lac_host.sv
// tb_lac_host: randomized self-checking bench for lac_host against a transaction-level protocol model
module tb_lac_host;
  localparam int AW = 4, TO = 50, N = 1 << AW;
  logic clk = 0, reset = 1, start = 0, abort = 0;
  logic [7:0] cfg_select = 0, cfg_mask = 0, cfg_cond = 0, cfg_pre = 0;
  logic [7:0] tx_data, rx_data = 0, sample_dat;
  logic tx_wr, tx_busy = 0, rx_avail = 0, rx_ack, sample_valid, busy, done, err;
  logic [AW-1:0] sample_idx;
  int tests = 0, fails = 0;
  int cyc = 0, acks = 0, dones = 0, last_sv = 0, last_ack = 0, err_rise = -1, busy_left = 0;
  logic prev_wr = 0, prev_err = 0;
  logic [7:0] txq[$], svq[$];
  int siq[$];

  lac_host #(.adr_width(AW), .timeout_cycles(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_select(cfg_select), .cfg_mask(cfg_mask), .cfg_cond(cfg_cond), .cfg_pre(cfg_pre),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
    .sample_dat(sample_dat), .sample_valid(sample_valid), .sample_idx(sample_idx),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // UART transmitter model plus observation of every strobe the DUT emits
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      busy_left = 0;
      tx_busy = 0;
      prev_wr = 0;
      prev_err = 0;
    end else begin
      if (tx_wr) begin
        check("tx_b2b", {31'd0, prev_wr}, 0);
        check("tx_while_busy", {31'd0, tx_busy}, 0);
        txq.push_back(tx_data);
        busy_left = $urandom_range(1, 10);
      end else if (busy_left > 0) busy_left--;
      tx_busy = busy_left > 0;
      prev_wr = tx_wr;
      if (rx_ack) begin
        acks++;
        last_ack = cyc;
      end
      if (sample_valid) begin
        check("sv_with_ack", {31'd0, rx_ack}, 1);
        svq.push_back(sample_dat);
        siq.push_back(int'(sample_idx));
        last_sv = cyc;
      end
      if (done) begin
        dones++;
        check("done_lat", cyc - last_sv, 1);
        check("done_busy", {31'd0, busy}, 0);
      end
      if (err && !prev_err) err_rise = cyc;
      prev_err = err;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    rx_data = b;
    rx_avail = 1;
    do begin
      @(negedge clk);
      t++;
    end while (!rx_ack && t < 40);
    check("rx_acked", {31'd0, rx_ack}, 1);
    rx_avail = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 300) begin
      tick();
      t++;
    end
    check("idle", {31'd0, busy}, 0);
    tick(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_wr"}, {31'd0, tx_wr}, 0);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 0);
    check({tag, "_rx_ack"}, {31'd0, rx_ack}, 0);
    check({tag, "_sv"}, {31'd0, sample_valid}, 0);
    check({tag, "_sdat"}, {24'd0, sample_dat}, 0);
    check({tag, "_sidx"}, {28'd0, sample_idx}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_err"}, {31'd0, err}, 0);
  endtask

  task automatic arm();
    logic [7:0] exp[5];
    int t = 0;
    exp[0] = 8'h01;
    exp[1] = 8'($urandom);
    exp[2] = 8'($urandom);
    exp[3] = 8'($urandom);
    exp[4] = 8'($urandom);
    cfg_select = exp[1];
    cfg_mask = exp[2];
    cfg_cond = exp[3];
    cfg_pre = exp[4];
    txq.delete();
    start = 1;
    tick();
    start = 0;
    cfg_select = ~exp[1];
    cfg_mask = ~exp[2];
    cfg_cond = ~exp[3];
    cfg_pre = ~exp[4];
    check("arm_err_clr", {31'd0, err}, 0);
    while (txq.size() < 5 && t < 200) begin
      tick();
      t++;
    end
    check("arm_count", txq.size(), 5);
    for (int i = 0; i < 5 && i < txq.size(); i++) check($sformatf("arm_byte%0d", i), {24'd0, txq[i]}, {24'd0, exp[i]});
    check("arm_busy", {31'd0, busy}, 1);
    txq.delete();
  endtask

  task automatic dump();
    logic [7:0] data[N];
    int a0, d0;
    arm();
    svq.delete();
    siq.delete();
    a0 = acks;
    d0 = dones;
    for (int i = 0; i < N; i++) data[i] = 8'($urandom);
    send(8'(AW));
    for (int i = 0; i < N; i++) begin
      tick($urandom_range(0, 5));
      send(data[i]);
    end
    wait_idle();
    check("dump_count", svq.size(), N);
    for (int i = 0; i < N && i < svq.size(); i++) begin
      check($sformatf("dump_dat%0d", i), {24'd0, svq[i]}, {24'd0, data[i]});
      check($sformatf("dump_idx%0d", i), siq[i], i);
    end
    check("dump_done", dones - d0, 1);
    check("dump_err", {31'd0, err}, 0);
    check("dump_acks", acks - a0, N + 1);
  endtask

  initial begin
    int t;
    logic [7:0] b;
    tick(3);
    check_reset_outputs("rst");
    reset = 0;
    tick();
    for (int rep = 0; rep < 2; rep++) begin
      dump();
      // bad header: error, back to idle, following bytes flushed without samples
      arm();
      b = 8'($urandom);
      if (b == 8'(AW)) b++;
      send(b);
      check("badhdr_err", {31'd0, err}, 1);
      check("badhdr_busy", {31'd0, busy}, 0);
      svq.delete();
      for (int i = 0; i < N; i++) send(8'($urandom));
      tick(2);
      check("badhdr_nosv", svq.size(), 0);
      // abort while waiting for the header
      arm();
      t = dones;
      abort = 1;
      tick();
      abort = 0;
      wait_idle();
      tick(15);
      check("abort_txcnt", txq.size(), 1);
      if (txq.size() > 0) check("abort_dis", {24'd0, txq[0]}, 32'h02);
      check("abort_nodone", dones - t, 0);
      check("abort_err", {31'd0, err}, 0);
      // timeout during the dump
      arm();
      t = dones;
      svq.delete();
      err_rise = -1;
      send(8'(AW));
      for (int i = 0; i < 3; i++) send(8'($urandom));
      for (int i = 0; i < 100 && !err; i++) tick();
      tick();
      check("tmo_err", {31'd0, err}, 1);
      check("tmo_lat", err_rise - last_ack, TO);
      check("tmo_busy", {31'd0, busy}, 0);
      tick(20);
      check("tmo_nodis", txq.size(), 0);
      check("tmo_samples", svq.size(), 3);
      check("tmo_nodone", dones - t, 0);
      // reset in the middle of a dump
      arm();
      svq.delete();
      send(8'(AW));
      for (int i = 0; i < 8; i++) send(8'($urandom));
      check("mid_idx", {28'd0, sample_idx}, 7);
      reset = 1;
      tick();
      check_reset_outputs("midrst");
      reset = 0;
      tick();
      dump();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
